// File: rtl/button_press_counter.sv
// Two-button debounced up/down press counter with one-cycle press pulses.
// Optional auto-repeat while a button is held: define AUTOREPEAT_EN.

module button_press_channel #(
    parameter int DEBOUNCE_CYCLES = 8
`ifdef AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 5
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int TW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          stable_q;
    logic          stable_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          rise;
    logic          pulse_d;

    // Any sample matching the accepted level restarts the stability window.
    always_comb begin
        stable_d = stable_q;
        timer_d  = '0;
        if (sync_q2 != stable_q) begin
            if (timer_q == T_MAX) begin
                stable_d = sync_q2;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    assign rise = stable_d & ~stable_q;

`ifdef AUTOREPEAT_EN
    localparam int RW = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [RW-1:0] R_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rpt_q;
    logic [RW-1:0] rpt_d;
    logic          rpt_hit;

    // Gated on the next level too, so a release edge never emits a repeat.
    always_comb begin
        rpt_d   = '0;
        rpt_hit = 1'b0;
        if (stable_q && stable_d) begin
            if (rpt_q == R_LAST) begin
                rpt_d   = R_RELOAD;
                rpt_hit = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    assign pulse_d = rise | rpt_hit;
`else
    assign pulse_d = rise;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stable_q <= 1'b0;
            timer_q  <= '0;
            pulse    <= 1'b0;
        end else begin
            sync_q1  <= btn;
            sync_q2  <= sync_q1;
            stable_q <= stable_d;
            timer_q  <= timer_d;
            pulse    <= pulse_d;
        end
    end

    assign level = stable_q;

endmodule

module button_press_counter #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 6,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic             up_db,
    output logic             down_db,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic [CNT_W-1:0] count
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 ||
        REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_param
        $error("button_press_counter: illegal parameter set");
    end

    button_press_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_up (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_up),
        .level(up_db),
        .pulse(up_pulse)
    );

    button_press_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTOREPEAT_EN
        ,
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_down (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_down),
        .level(down_db),
        .pulse(down_pulse)
    );

    // Simultaneous up and down presses cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({up_pulse, down_pulse})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
